// File: rtl/voice_alloc.sv
// voice_alloc: polyphonic voice allocator placed directly upstream of the
// per-voice adsr envelope generators. It turns a note-on/note-off event
// stream into one gate, note number and velocity per voice.
//
// Voice choice for a note-on, in priority order:
//   1. A voice that is already gated on the same note (retrigger).
//   2. The oldest voice that is not gated and whose envelope is silent.
//   3. The oldest voice that is not gated (its envelope is still releasing).
//   4. The oldest voice overall (steal).
// When the chosen voice is still gated, its gate is dropped for exactly one
// cycle so that the envelope sees a fresh rising edge.
//
// State table:
//   state  | meaning
//   IDLE   | ready for an event; a note-off takes effect at its accept edge
//   SELECT | note-on latched; choose a voice using gate and voice_active
//   RETRIG | chosen voice is held low for one cycle; assign it at the next edge
//
// Ports:
//   clk          clock
//   reset        asynchronous, active-high reset
//   ev_valid     event present
//   ev_ready     allocator can accept an event (high only in IDLE)
//   ev_on        1 = note-on, 0 = note-off
//   ev_note      event note number
//   ev_vel       event velocity (ignored for note-off)
//   voice_active per-voice envelope active flag, sampled only in SELECT
//   gate         per-voice gate, registered
//   note         voice i note at [i*NOTE_BITS +: NOTE_BITS], registered
//   vel          voice i velocity, same packing, registered
module voice_alloc #(
    parameter int VOICES    = 4,
    parameter int NOTE_BITS = 7,
    parameter int VEL_BITS  = 7
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ev_valid,
    output logic                          ev_ready,
    input  logic                          ev_on,
    input  logic [NOTE_BITS-1:0]          ev_note,
    input  logic [VEL_BITS-1:0]           ev_vel,
    input  logic [VOICES-1:0]             voice_active,
    output logic [VOICES-1:0]             gate,
    output logic [VOICES*NOTE_BITS-1:0]   note,
    output logic [VOICES*VEL_BITS-1:0]    vel
);

    localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        RETRIG = 2'd2
    } state_t;

    state_t state, state_nx;

    // age[i] is a permutation of 0..VOICES-1; the largest value is the
    // least-recently-assigned voice.
    logic [VOICES-1:0][VW-1:0]    age, age_nx;
    logic [VOICES-1:0]            gate_nx;
    logic [VOICES*NOTE_BITS-1:0]  note_nx;
    logic [VOICES*VEL_BITS-1:0]   vel_nx;
    logic [NOTE_BITS-1:0]         lat_note, lat_note_nx;
    logic [VEL_BITS-1:0]          lat_vel, lat_vel_nx;
    logic [VW-1:0]                lat_v, lat_v_nx;

    logic [VOICES-1:0]            m_match, m_free, m_rel;
    logic [VW:0]                  p_match, p_free, p_rel, p_all;
    logic [VW-1:0]                sel_v;
    logic                         assign_en;
    logic [VW-1:0]                assign_v;

    // Returns {found, index} of the oldest voice set in mask.
    function automatic logic [VW:0] pick_oldest(
        input logic [VOICES-1:0]          mask,
        input logic [VOICES-1:0][VW-1:0]  ages
    );
        logic          found;
        logic [VW-1:0] idx;
        logic [VW-1:0] best;
        found = 1'b0;
        idx   = '0;
        best  = '0;
        for (int i = 0; i < VOICES; i++) begin
            if (mask[i] && (!found || ages[i] > best)) begin
                found = 1'b1;
                idx   = VW'(i);
                best  = ages[i];
            end
        end
        return {found, idx};
    endfunction

    assign ev_ready = (state == IDLE);

    always_comb begin
        m_match = '0;
        m_free  = '0;
        m_rel   = '0;
        for (int i = 0; i < VOICES; i++) begin
            m_match[i] = gate[i] && (note[i*NOTE_BITS +: NOTE_BITS] == lat_note);
            m_free[i]  = !gate[i] && !voice_active[i];
            m_rel[i]   = !gate[i];
        end
    end

    assign p_match = pick_oldest(m_match, age);
    assign p_free  = pick_oldest(m_free, age);
    assign p_rel   = pick_oldest(m_rel, age);
    assign p_all   = pick_oldest({VOICES{1'b1}}, age);

    assign sel_v = p_match[VW] ? p_match[VW-1:0] :
                   p_free[VW]  ? p_free[VW-1:0]  :
                   p_rel[VW]   ? p_rel[VW-1:0]   :
                                 p_all[VW-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        gate_nx     = gate;
        note_nx     = note;
        vel_nx      = vel;
        age_nx      = age;
        lat_note_nx = lat_note;
        lat_vel_nx  = lat_vel;
        lat_v_nx    = lat_v;
        assign_en   = 1'b0;
        assign_v    = lat_v;

        case (state)
            IDLE: begin
                if (ev_valid) begin
                    if (ev_on) begin
                        lat_note_nx = ev_note;
                        lat_vel_nx  = ev_vel;
                        state_nx    = SELECT;
                    end else begin
                        for (int i = 0; i < VOICES; i++) begin
                            if (gate[i] && note[i*NOTE_BITS +: NOTE_BITS] == ev_note) begin
                                gate_nx[i] = 1'b0;
                            end
                        end
                    end
                end
            end
            SELECT: begin
                if (!gate[sel_v]) begin
                    assign_en = 1'b1;
                    assign_v  = sel_v;
                    state_nx  = IDLE;
                end else begin
                    // Still gated: drop it for one cycle before reassigning.
                    gate_nx[sel_v] = 1'b0;
                    lat_v_nx       = sel_v;
                    state_nx       = RETRIG;
                end
            end
            RETRIG: begin
                assign_en = 1'b1;
                assign_v  = lat_v;
                state_nx  = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        if (assign_en) begin
            for (int i = 0; i < VOICES; i++) begin
                if (VW'(i) == assign_v) begin
                    gate_nx[i]                          = 1'b1;
                    note_nx[i*NOTE_BITS +: NOTE_BITS]   = lat_note;
                    vel_nx[i*VEL_BITS +: VEL_BITS]      = lat_vel;
                    age_nx[i]                           = '0;
                end else if (age[i] < age[assign_v]) begin
                    age_nx[i] = age[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gate     <= '0;
            note     <= '0;
            vel      <= '0;
            lat_note <= '0;
            lat_vel  <= '0;
            lat_v    <= '0;
            for (int i = 0; i < VOICES; i++) begin
                age[i] <= VW'(i);
            end
        end else begin
            gate     <= gate_nx;
            note     <= note_nx;
            vel      <= vel_nx;
            lat_note <= lat_note_nx;
            lat_vel  <= lat_vel_nx;
            lat_v    <= lat_v_nx;
            age      <= age_nx;
        end
    end

endmodule

// File: tb/tb_voice_alloc.sv
module tb_voice_alloc;

    localparam int V  = 4;
    localparam int NB = 7;
    localparam int VB = 7;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              ev_valid = 1'b0;
    logic              ev_ready;
    logic              ev_on = 1'b0;
    logic [NB-1:0]     ev_note = '0;
    logic [VB-1:0]     ev_vel = '0;
    logic [V-1:0]      voice_active = '0;
    logic [V-1:0]      gate;
    logic [V*NB-1:0]   note;
    logic [V*VB-1:0]   vel;

    int vectors = 0;
    int miscompares = 0;

    // 0: active follows gate, 1: active forced, 2: gate | random release tails
    int           act_mode = 0;
    logic [V-1:0] act_force = '0;

    voice_alloc #(.VOICES(V), .NOTE_BITS(NB), .VEL_BITS(VB)) dut (
        .clk          (clk),
        .reset        (reset),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_on        (ev_on),
        .ev_note      (ev_note),
        .ev_vel       (ev_vel),
        .voice_active (voice_active),
        .gate         (gate),
        .note         (note),
        .vel          (vel)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // lru holds voice numbers, most recently assigned first.
    bit [V-1:0]    m_gate = '0;
    logic [NB-1:0] m_note [V] = '{default: '0};
    logic [VB-1:0] m_vel  [V] = '{default: '0};
    int            lru[$] = '{0, 1, 2, 3};
    int            m_phase = 0;    // 0 ready, 1 choosing, 2 gap cycle
    logic [NB-1:0] p_note = '0;
    logic [VB-1:0] p_vel = '0;
    int            p_v = 0;

    function automatic int oldest_of(input bit [V-1:0] mask);
        for (int k = lru.size() - 1; k >= 0; k--)
            if (mask[lru[k]]) return lru[k];
        return -1;
    endfunction

    function automatic int choose_voice();
        bit [V-1:0] mm, mf, mr;
        mm = '0; mf = '0; mr = '0;
        for (int i = 0; i < V; i++) begin
            mm[i] = m_gate[i] && (m_note[i] == p_note);
            mf[i] = !m_gate[i] && !voice_active[i];
            mr[i] = !m_gate[i];
        end
        if (mm != 0) return oldest_of(mm);
        if (mf != 0) return oldest_of(mf);
        if (mr != 0) return oldest_of(mr);
        return oldest_of('1);
    endfunction

    task automatic give(input int v);
        m_gate[v] = 1'b1;
        m_note[v] = p_note;
        m_vel[v]  = p_vel;
        for (int k = 0; k < lru.size(); k++)
            if (lru[k] == v) begin lru.delete(k); break; end
        lru.push_front(v);
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_phase = 0;
            m_gate  = '0;
            for (int i = 0; i < V; i++) begin m_note[i] = '0; m_vel[i] = '0; end
            lru = '{0, 1, 2, 3};
        end else begin
            case (m_phase)
                0: if (ev_valid) begin
                    if (ev_on) begin
                        p_note  = ev_note;
                        p_vel   = ev_vel;
                        m_phase = 1;
                    end else begin
                        for (int i = 0; i < V; i++)
                            if (m_gate[i] && m_note[i] == ev_note) m_gate[i] = 1'b0;
                    end
                end
                1: begin
                    int v;
                    v = choose_voice();
                    if (m_gate[v]) begin
                        m_gate[v] = 1'b0;
                        p_v       = v;
                        m_phase   = 2;
                    end else begin
                        give(v);
                        m_phase = 0;
                    end
                end
                default: begin
                    give(p_v);
                    m_phase = 0;
                end
            endcase
        end
    end

    // voice_active driven away from the active edge
    initial forever begin
        @(negedge clk);
        case (act_mode)
            0:       voice_active = gate;
            1:       voice_active = act_force;
            default: voice_active = gate | 4'($urandom_range(0, 15));
        endcase
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        vectors++;
        if (gate !== m_gate) begin
            miscompares++;
            $display("FAIL gate t=%0t got=%b want=%b", $time, gate, m_gate);
        end
        if (ev_ready !== (m_phase == 0)) begin
            miscompares++;
            $display("FAIL ev_ready t=%0t got=%b want=%b", $time, ev_ready, (m_phase == 0));
        end
        for (int i = 0; i < V; i++) begin
            if (note[i*NB +: NB] !== m_note[i]) begin
                miscompares++;
                $display("FAIL note%0d t=%0t got=%0d want=%0d", i, $time, note[i*NB +: NB], m_note[i]);
            end
            if (vel[i*VB +: VB] !== m_vel[i]) begin
                miscompares++;
                $display("FAIL vel%0d t=%0t got=%0d want=%0d", i, $time, vel[i*VB +: VB], m_vel[i]);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] vnote(input int i);
        return 32'(note[i*NB +: NB]);
    endfunction

    function automatic logic [31:0] vvel(input int i);
        return 32'(vel[i*VB +: VB]);
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input bit on, input int n, input int v);
        int t;
        t = 0;
        while (!ev_ready && t < 20) begin @(negedge clk); t++; end
        if (t >= 20) begin
            miscompares++;
            $display("FAIL send_wait t=%0t ev_ready stuck low", $time);
        end
        ev_valid = 1'b1;
        ev_on    = on;
        ev_note  = NB'(n);
        ev_vel   = VB'(v);
        @(negedge clk);
        ev_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        lit("rst_gate", 32'(gate), 0);
        lit("rst_ready", 32'(ev_ready), 1);
        reset = 1'b0;
        @(negedge clk);

        send(1, 60, 100);
        lit("on60_ready", 32'(ev_ready), 0);
        @(negedge clk);
        lit("on60_gate", 32'(gate), 32'h8);
        lit("on60_note3", vnote(3), 60);
        lit("on60_vel3", vvel(3), 100);
        lit("on60_ready2", 32'(ev_ready), 1);

        send(1, 62, 11);
        send(1, 64, 12);
        send(1, 65, 13);
        @(negedge clk);
        lit("fill_gate", 32'(gate), 32'hF);
        lit("fill_note2", vnote(2), 62);
        lit("fill_note1", vnote(1), 64);
        lit("fill_note0", vnote(0), 65);

        send(1, 67, 1);
        lit("steal_e0", 32'(gate), 32'hF);
        @(negedge clk);
        lit("steal_gap", 32'(gate), 32'h7);
        lit("steal_ready", 32'(ev_ready), 0);
        @(negedge clk);
        lit("steal_gate", 32'(gate), 32'hF);
        lit("steal_note3", vnote(3), 67);

        send(0, 62, 0);
        lit("off62_gate", 32'(gate), 32'hB);
        lit("off62_ready", 32'(ev_ready), 1);
        send(0, 70, 0);
        lit("off70_gate", 32'(gate), 32'hB);

        act_mode  = 1;
        act_force = 4'b1111;
        @(negedge clk);
        send(1, 66, 5);
        @(negedge clk);
        lit("rel_on66", 32'(gate), 32'hF);
        lit("rel_note2", vnote(2), 66);
        send(0, 64, 0);
        lit("off64_gate", 32'(gate), 32'hD);
        send(1, 69, 7);
        @(negedge clk);
        lit("rel_on69", 32'(gate), 32'hF);
        lit("rel_note1", vnote(1), 69);
        lit("keep_note0", vnote(0), 65);
        lit("keep_note3", vnote(3), 67);

        act_force = 4'b1101;
        send(0, 66, 0);
        send(0, 69, 0);
        lit("two_off_gate", 32'(gate), 32'h9);
        send(1, 71, 9);
        @(negedge clk);
        lit("free_gate", 32'(gate), 32'hB);
        lit("free_note1", vnote(1), 71);

        send(1, 62, 50);
        @(negedge clk);
        lit("v2_62_gate", 32'(gate), 32'hF);
        lit("v2_62_note", vnote(2), 62);
        send(1, 62, 90);
        @(negedge clk);
        lit("retrig_gap", 32'(gate), 32'hB);
        @(negedge clk);
        lit("retrig_gate", 32'(gate), 32'hF);
        lit("retrig_vel2", vvel(2), 90);

        send(1, 62, 10);
        @(negedge clk);
        lit("rst_mid_gap", 32'(gate), 32'hB);
        #1 reset = 1'b1;
        #1;
        lit("rst_mid_gate", 32'(gate), 0);
        lit("rst_mid_note", (note == '0) ? 32'd1 : 32'd0, 1);
        lit("rst_mid_ready", 32'(ev_ready), 1);
        @(negedge clk);
        reset    = 1'b0;
        act_mode = 0;
        @(negedge clk);
        send(1, 60, 100);
        @(negedge clk);
        lit("after_rst_gate", 32'(gate), 32'h8);
        lit("after_rst_note3", vnote(3), 60);

        act_mode = 2;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            ev_valid = 1'($urandom_range(0, 1));
            ev_on    = 1'($urandom_range(0, 1));
            ev_note  = NB'(60 + $urandom_range(0, 7));
            ev_vel   = VB'($urandom_range(0, 127));
            if ($urandom_range(0, 599) == 0) begin
                #1 reset = 1'b1;
                #2 reset = 1'b0;
            end
        end
        ev_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
